// File: rtl/ps2_code_fifo.sv
// PS/2 make-code buffer: rising-edge detect on PS2_code_ready, optional typematic-repeat
// suppression, and a first-word-fall-through FIFO read through a valid/ready handshake.
//
// Held-key tracker states:
//   state | meaning
//   IDLE  | no key held; any make code is a push candidate
//   HELD  | last accepted make (last_make_q) still held; an identical make is a repeat
module ps2_code_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int DROP_REPEAT = 1
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic [7:0]        PS2_code,
  input  logic              PS2_code_ready,
  input  logic              PS2_make_code,
  input  logic              flush,
  output logic              code_valid,
  output logic [7:0]        code_data,
  input  logic              code_ready,
  output logic [ADDR_W:0]   fill_level,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        overflow_count
);

  typedef enum logic {IDLE, HELD} held_state_e;

  localparam logic [ADDR_W:0] DEPTH_F = (ADDR_W + 1)'(DEPTH);

  held_state_e       state_q, state_d;
  logic              ready_buf_q, ready_buf_d;
  logic [7:0]        last_make_q, last_make_d;
  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0]   fill_q, fill_d, fill_after_pop;
  logic [7:0]        data_q, data_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        ovf_cnt_q, ovf_cnt_d;
  logic [7:0]        mem_q [DEPTH];

  logic ev, is_repeat, cand, pop, push, drop, full_w;

  always_comb begin
    ev        = PS2_code_ready & ~ready_buf_q;
    is_repeat = (DROP_REPEAT != 0) && (state_q == HELD) && (PS2_code == last_make_q);
    cand      = ev & PS2_make_code & ~is_repeat;
    full_w    = (fill_q == DEPTH_F);
    pop       = (fill_q != '0) & code_ready & ~flush;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    push      = cand & ~flush & (~full_w | pop);
    drop      = cand & ~flush & full_w & ~pop;

    ready_buf_d = PS2_code_ready;
    state_d     = state_q;
    last_make_d = last_make_q;
    if (flush) begin
      state_d = IDLE;
    end else if (ev & ~PS2_make_code) begin
      state_d = IDLE;
    end else if (cand) begin
      state_d     = HELD;
      last_make_d = PS2_code;
    end

    wr_d           = wr_q + ADDR_W'(push);
    rd_d           = rd_q + ADDR_W'(pop);
    fill_d         = fill_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    fill_after_pop = fill_q - (ADDR_W + 1)'(pop);
    if (flush) begin
      wr_d   = '0;
      rd_d   = '0;
      fill_d = '0;
    end

    // next head: empty reads as 0; a push into a drained FIFO bypasses the RAM
    if (fill_d == '0)
      data_d = 8'h00;
    else if (fill_after_pop == '0)
      data_d = PS2_code;
    else
      data_d = mem_q[rd_d];

    ovf_d     = ovf_q | drop;
    ovf_cnt_d = (drop && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ready_buf_q <= 1'b0;
      last_make_q <= 8'h00;
      wr_q        <= '0;
      rd_q        <= '0;
      fill_q      <= '0;
      data_q      <= 8'h00;
      ovf_q       <= 1'b0;
      ovf_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      ready_buf_q <= ready_buf_d;
      last_make_q <= last_make_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (push) mem_q[wr_q] <= PS2_code;
  end

  assign code_valid     = (fill_q != '0);
  assign code_data      = data_q;
  assign fill_level     = fill_q;
  assign full           = full_w;
  assign overflow       = ovf_q;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_ps2_code_fifo.sv
// Directed bench for ps2_code_fifo (DEPTH=16, DROP_REPEAT=1) with immediate-assertion checks.
module tb_ps2_code_fifo;

  logic       Clock_50 = 1'b0;
  logic       Reset;
  logic [7:0] PS2_code;
  logic       PS2_code_ready;
  logic       PS2_make_code;
  logic       flush;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_ready;
  logic [4:0] fill_level;
  logic       full;
  logic       overflow;
  logic [7:0] overflow_count;

  int total = 0;
  int bad   = 0;

  ps2_code_fifo #(.DEPTH(16), .ADDR_W(4), .DROP_REPEAT(1)) dut (
    .Clock_50      (Clock_50),
    .Reset         (Reset),
    .PS2_code      (PS2_code),
    .PS2_code_ready(PS2_code_ready),
    .PS2_make_code (PS2_make_code),
    .flush         (flush),
    .code_valid    (code_valid),
    .code_data     (code_data),
    .code_ready    (code_ready),
    .fill_level    (fill_level),
    .full          (full),
    .overflow      (overflow),
    .overflow_count(overflow_count)
  );

  always #10 Clock_50 = ~Clock_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock_50);
    #1;
  endtask

  // one ready rise carrying code/make, then ready low for a cycle
  task automatic send(input logic [7:0] code, input logic make);
    PS2_code       = code;
    PS2_make_code  = make;
    PS2_code_ready = 1'b1;
    step();
    PS2_code_ready = 1'b0;
    step();
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_code;
  logic       rdy, prev_rdy, pop_m, ev_m;
  int         sent, drops;

  initial begin
    Reset = 1'b1; PS2_code = 8'h00; PS2_code_ready = 1'b0; PS2_make_code = 1'b0;
    flush = 1'b0; code_ready = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();

    // 1: reset state and first make latency
    chk("rst_valid", code_valid, 0);
    chk("rst_data", code_data, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ovf_cnt", overflow_count, 0);
    PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    chk("t1_valid_pre", code_valid, 0);
    step();
    chk("t1_valid", code_valid, 1);
    chk("t1_data", code_data, 8'h1C);
    chk("t1_fill", fill_level, 1);
    PS2_code_ready = 1'b0;
    step();
    code_ready = 1'b1;
    step();
    code_ready = 1'b0;
    chk("t1_pop_fill", fill_level, 0);
    chk("t1_pop_valid", code_valid, 0);
    chk("t1_pop_data", code_data, 0);

    // 2: repeat suppression and level-held ready
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b1);
    chk("t2_repeat_fill", fill_level, 1);
    send(8'h1C, 1'b0);
    PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    repeat (10) step();
    PS2_code_ready = 1'b0;
    step();
    chk("t2_fill", fill_level, 2);
    chk("t2_head0", code_data, 8'h1C);
    code_ready = 1'b1;
    step();
    chk("t2_head1", code_data, 8'h1C);
    chk("t2_fill1", fill_level, 1);
    step();
    code_ready = 1'b0;
    chk("t2_empty", fill_level, 0);
    send(8'h1C, 1'b0);

    // 3: overfill by one
    for (int i = 0; i < 17; i++) send(8'(8'h20 + i), 1'b1);
    chk("t3_full", full, 1);
    chk("t3_fill", fill_level, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_ovf_cnt", overflow_count, 1);
    chk("t3_head", code_data, 8'h20);

    // 4: push while full with simultaneous pop
    PS2_code = 8'h40; PS2_make_code = 1'b1; PS2_code_ready = 1'b1; code_ready = 1'b1;
    step();
    PS2_code_ready = 1'b0; code_ready = 1'b0;
    chk("t4_fill", fill_level, 16);
    chk("t4_ovf_cnt", overflow_count, 1);
    chk("t4_head", code_data, 8'h21);
    step();
    code_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_code = (i < 15) ? 8'(8'h21 + i) : 8'h40;
      chk("t3_t4_order", code_data, exp_code);
      step();
    end
    code_ready = 1'b0;
    chk("t4_empty_fill", fill_level, 0);
    chk("t4_empty_valid", code_valid, 0);

    // 5: streamed codes, random consumer, scoreboard
    sent = 0; drops = 0; prev_rdy = 1'b0;
    for (int c = 0; c < 2000 && !(sent == 40 && q.size() == 0); c++) begin
      rdy            = (sent < 40) && (c % 2 == 0);
      exp_code       = 8'(8'h50 + sent);
      PS2_code       = exp_code;
      PS2_make_code  = 1'b1;
      PS2_code_ready = rdy;
      code_ready     = 1'($urandom_range(0, 1));
      ev_m  = rdy & ~prev_rdy;
      pop_m = (q.size() > 0) && code_ready;
      chk("t5_valid", code_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) chk("t5_head", code_data, q[0]);
      if (pop_m) void'(q.pop_front());
      if (ev_m) begin
        if (q.size() < 16) q.push_back(exp_code);
        else drops++;
        sent++;
      end
      prev_rdy = rdy;
      step();
      chk("t5_fill", fill_level, q.size());
    end
    PS2_code_ready = 1'b0; code_ready = 1'b0;
    chk("t5_done", (sent == 40 && q.size() == 0) ? 1 : 0, 1);
    chk("t5_ovf_cnt", overflow_count, 1 + drops);
    step();

    // 6: flush with ev and pop in the same cycle, then Reset mid-stream
    send(8'h11, 1'b1);
    send(8'h12, 1'b1);
    chk("t6_pre_fill", fill_level, 2);
    PS2_code = 8'h13; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    code_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; code_ready = 1'b0; PS2_code_ready = 1'b0;
    chk("t6_flush_fill", fill_level, 0);
    chk("t6_flush_valid", code_valid, 0);
    chk("t6_flush_data", code_data, 0);
    chk("t6_flush_ovf", overflow, 1);
    chk("t6_flush_ovf_cnt", overflow_count, 1 + drops);
    step();
    send(8'h12, 1'b1);
    chk("t6_held_cleared", fill_level, 1);
    chk("t6_held_data", code_data, 8'h12);
    send(8'h14, 1'b1);
    chk("t6_pre_rst_fill", fill_level, 2);
    Reset = 1'b1;
    #1;
    chk("t6_rst_fill", fill_level, 0);
    chk("t6_rst_valid", code_valid, 0);
    chk("t6_rst_ovf_cnt", overflow_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    step();
    Reset = 1'b0;
    step();
    chk("t6_after_rst_data", code_data, 0);
    chk("t6_after_rst_fill", fill_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
